// File: rtl/joy_adc_pkg.sv
// Shared types for the joystick ADC scan path.
//   scan_state_t : sequencer states of joy_adc_scan
//   SLOT_*       : slot codes on s, also decoded by the downstream threshold stage
package joy_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PULSE,
        WAIT_LOW,
        WAIT_HIGH,
        READ,
        DONE
    } scan_state_t;

    localparam logic [2:0] SLOT_NONE = 3'b000;
    localparam logic [2:0] SLOT_X    = 3'b001;
    localparam logic [2:0] SLOT_Y    = 3'b010;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk, rst_n : destination clock, async active-low reset (output resets to 0)
//   d          : asynchronous input
//   q          : synchronised output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/joy_adc_scan.sv
// Scans the joystick X/Y channels of an ADC0809-class converter, alternating
// X and Y, and hands each result downstream as dout with a one-cycle eoc.
//   clk, rst_n          : system clock, async active-low reset
//   adc_eoc, adc_data   : raw EOC pin (asynchronous) and ADC data bus
//   adc_clk             : free-running conversion clock for the ADC
//   adc_addr            : mux address, updated on ADDR entry only
//   adc_ale, adc_start  : latch/start pulse, PULSE_CYC wide
//   adc_oe              : output enable, OE_CYC wide
//   s, eoc, dout        : slot tag, result strobe, last result
//   timeout_err         : one-cycle pulse when a conversion is abandoned
module joy_adc_scan
    import joy_adc_pkg::*;
#(
    parameter int         ADC_CLK_DIV = 50,
    parameter logic [2:0] CH_X        = 3'd0,
    parameter logic [2:0] CH_Y        = 3'd1,
    parameter int         ADDR_SETUP  = 4,
    parameter int         PULSE_CYC   = 10,
    parameter int         OE_CYC      = 4,
    parameter int         GAP_CYC     = 1000,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adc_eoc,
    input  logic [7:0] adc_data,
    output logic       adc_clk,
    output logic [2:0] adc_addr,
    output logic       adc_ale,
    output logic       adc_start,
    output logic       adc_oe,
    output logic [2:0] s,
    output logic       eoc,
    output logic [7:0] dout,
    output logic       timeout_err
);

    // One phase counter serves every timed state, so it is sized for the longest.
    localparam int PH_A   = (GAP_CYC > ADDR_SETUP) ? GAP_CYC : ADDR_SETUP;
    localparam int PH_B   = (PULSE_CYC > OE_CYC) ? PULSE_CYC : OE_CYC;
    localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int DIV_W  = (ADC_CLK_DIV > 1) ? $clog2(ADC_CLK_DIV) : 1;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYC - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(ADDR_SETUP - 1);
    localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0]  OE_LAST    = PH_W'(OE_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(ADC_CLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    scan_state_t      state, state_n;
    logic [PH_W-1:0]  ph_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic             eoc_s;
    logic             sel_y;
    logic             to_fire;

    sync_2ff u_eoc_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (adc_eoc),
        .q     (eoc_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A stale EOC high at WAIT_LOW entry is ignored: the ADC must drop EOC
    // before a rising edge counts as a finished conversion.
    always_comb begin
        state_n = state;
        to_fire = 1'b0;
        case (state)
            IDLE:      if (ph_cnt == GAP_LAST)   state_n = ADDR;
            ADDR:      if (ph_cnt == SETUP_LAST) state_n = PULSE;
            PULSE:     if (ph_cnt == PULSE_LAST) state_n = WAIT_LOW;
            WAIT_LOW: begin
                if (!eoc_s) begin
                    state_n = WAIT_HIGH;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_HIGH: begin
                if (eoc_s) begin
                    state_n = READ;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_n = IDLE;
                end
            end
            READ:      if (ph_cnt == OE_LAST)    state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    assign adc_ale   = (state == PULSE);
    assign adc_start = (state == PULSE);
    assign adc_oe    = (state == READ);
    assign eoc       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ph_cnt      <= '0;
            to_cnt      <= '0;
            adc_addr    <= '0;
            s           <= SLOT_NONE;
            dout        <= '0;
            sel_y       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            timeout_err <= to_fire;

            if (state_n != state)  ph_cnt <= '0;
            else if (ph_cnt != '1) ph_cnt <= ph_cnt + 1'b1;

            // Timeout budget spans WAIT_LOW and WAIT_HIGH together.
            if (state == WAIT_LOW || state == WAIT_HIGH) begin
                if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
            end else begin
                to_cnt <= '0;
            end

            if (state == IDLE && state_n == ADDR) begin
                adc_addr <= sel_y ? CH_Y : CH_X;
                s        <= sel_y ? SLOT_Y : SLOT_X;
            end

            if (state == READ && ph_cnt == OE_LAST) dout <= adc_data;

            if (to_fire || state == DONE) sel_y <= ~sel_y;
        end
    end

endmodule
